// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two requester ports, their response strobes and the 8x8 memory-array bus.
// slave is the arbiter's view, master is the requester/memory side.
interface mem_arbiter_if;
  logic       req0_valid, req0_rw, req0_ready, rsp0_valid;
  logic [2:0] req0_addr;
  logic [7:0] req0_wdata, rsp0_rdata;
  logic       req1_valid, req1_rw, req1_ready, rsp1_valid;
  logic [2:0] req1_addr;
  logic [7:0] req1_wdata, rsp1_rdata;
  logic [7:0] mem_sel, mem_wdata, mem_rdata;
  logic       mem_rw;
  modport slave (
    input  req0_valid, req0_rw, req0_addr, req0_wdata,
    input  req1_valid, req1_rw, req1_addr, req1_wdata,
    input  mem_rdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_sel, mem_rw, mem_wdata
  );
  modport master (
    output req0_valid, req0_rw, req0_addr, req0_wdata,
    output req1_valid, req1_rw, req1_addr, req1_wdata,
    output mem_rdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_sel, mem_rw, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter for an 8x8 memory array (IDLE -> ACCESS -> RESP).
// Round-robin by default; define MEM_ARB_FIXED_PRIORITY_EN to make requester 0 always win ties.
module mem_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);
  state_e     state_q, state_d;
  logic       gnt_q, gnt_d, rw_q, rw_d;
  logic [2:0] addr_q, addr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic       any_req, pick1, idle, access;
  assign any_req = bus.req0_valid | bus.req1_valid;
  assign idle    = (state_q == IDLE);
  assign access  = (state_q == ACCESS);
`ifdef MEM_ARB_FIXED_PRIORITY_EN
  assign pick1 = bus.req1_valid & ~bus.req0_valid;
`else
  logic last_q, last_d;
  // last_q = 1 means requester 1 had the previous grant, so requester 0 wins a tie
  assign pick1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      last_q   <= last_d;
`endif
    end
  end
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: if (any_req) begin
        state_d = ACCESS;
        gnt_d   = pick1;
        rw_d    = pick1 ? bus.req1_rw    : bus.req0_rw;
        addr_d  = pick1 ? bus.req1_addr  : bus.req0_addr;
        wdata_d = pick1 ? bus.req1_wdata : bus.req0_wdata;
        cnt_d   = '0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
        last_d  = pick1;
`endif
      end
      // response word is loaded straight into the owner's holding register on the last access cycle
      ACCESS: if (cnt_q == LAST) begin
        state_d = RESP;
        if (gnt_q) rdata1_d = rw_q ? wdata_q : bus.mem_rdata;
        else       rdata0_d = rw_q ? wdata_q : bus.mem_rdata;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.req0_ready = ~rst & idle & bus.req0_valid & ~pick1;
  assign bus.req1_ready = ~rst & idle & pick1;
  assign bus.rsp0_valid = (state_q == RESP) & ~gnt_q;
  assign bus.rsp1_valid = (state_q == RESP) & gnt_q;
  assign bus.rsp0_rdata = rdata0_q;
  assign bus.rsp1_rdata = rdata1_q;
  assign bus.mem_sel    = access ? (8'h01 << addr_q) : 8'h00;
  assign bus.mem_rw     = access & rw_q;
  assign bus.mem_wdata  = access ? wdata_q : 8'h00;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with ACCESS_CYCLES=1 (instance a) and 3 (instance b).
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;
  logic own;
  logic [7:0] mem [8];
  always #5 clk = ~clk;
  mem_arbiter_if a();
  mem_arbiter_if b();
  mem_arbiter #(.ACCESS_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(a));
  mem_arbiter #(.ACCESS_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b));
  always @(posedge clk or posedge rst)
    for (int i = 0; i < 8; i++)
      if (rst) mem[i] <= 8'h10 + 8'(i);
      else if (a.mem_rw && a.mem_sel[i]) mem[i] <= a.mem_wdata;
  always_comb begin
    a.mem_rdata = 8'h00;
    for (int i = 0; i < 8; i++)
      if (a.mem_sel[i]) a.mem_rdata = a.mem_rdata | mem[i];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    {a.req0_valid, a.req0_rw, a.req0_addr, a.req0_wdata} = '0;
    {a.req1_valid, a.req1_rw, a.req1_addr, a.req1_wdata} = '0;
    {b.req0_valid, b.req0_rw, b.req0_addr, b.req0_wdata} = '0;
    {b.req1_valid, b.req1_rw, b.req1_addr, b.req1_wdata} = '0;
    b.mem_rdata = 8'h5C;
    #2;
    chk("rst_sel", a.mem_sel, 8'h00);
    chk("rst_rw", a.mem_rw, 0);
    chk("rst_rdy0", a.req0_ready, 0);
    chk("rst_rsp0", a.rsp0_valid, 0);
    chk("rst_rsp1", a.rsp1_valid, 0);
    chk("rst_rdata0", a.rsp0_rdata, 8'h00);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    a.req0_valid = 1; a.req0_rw = 1; a.req0_addr = 3; a.req0_wdata = 8'hA5;
    #1 chk("wr_rdy0", a.req0_ready, 1);
    chk("wr_rdy1", a.req1_ready, 0);
    chk("wr_idle_sel", a.mem_sel, 8'h00);
    @(negedge clk) a.req0_valid = 0;
    #1 chk("wr_sel", a.mem_sel, 8'h08);
    chk("wr_rw", a.mem_rw, 1);
    chk("wr_wdata", a.mem_wdata, 8'hA5);
    chk("wr_acc_rdy0", a.req0_ready, 0);
    @(negedge clk);
    #1 chk("wr_rsp0", a.rsp0_valid, 1);
    chk("wr_rdata", a.rsp0_rdata, 8'hA5);
    chk("wr_rsp1", a.rsp1_valid, 0);
    chk("wr_resp_sel", a.mem_sel, 8'h00);
    @(negedge clk) begin a.req0_valid = 1; a.req0_rw = 0; a.req0_addr = 3; end
    #1 chk("rd_rdy0", a.req0_ready, 1);
    @(negedge clk) a.req0_valid = 0;
    #1 chk("rd_sel", a.mem_sel, 8'h08);
    chk("rd_rw", a.mem_rw, 0);
    @(negedge clk);
    #1 chk("rd_rsp0", a.rsp0_valid, 1);
    chk("rd_rdata", a.rsp0_rdata, 8'hA5);
    @(negedge clk);
    #1 chk("rd_rsp0_off", a.rsp0_valid, 0);
    chk("rd_hold", a.rsp0_rdata, 8'hA5);
    // fresh reset so the pointer starts at 1 for the tie
    @(negedge clk) rst = 1'b1;
    #1 rst = 1'b0;
    a.req0_valid = 1; a.req0_rw = 0; a.req0_addr = 0;
    a.req1_valid = 1; a.req1_rw = 0; a.req1_addr = 7;
    for (int g = 0; g < 8; g++) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      own = 1'b0;
`else
      own = (g % 2) == 1;
`endif
      #1 chk($sformatf("b2b%0d_rdy0", g), a.req0_ready, !own);
      chk($sformatf("b2b%0d_rdy1", g), a.req1_ready, own);
      @(negedge clk);
      #1 chk($sformatf("b2b%0d_sel", g), a.mem_sel, own ? 8'h80 : 8'h01);
      @(negedge clk);
      #1 chk($sformatf("b2b%0d_rsp0", g), a.rsp0_valid, !own);
      chk($sformatf("b2b%0d_rsp1", g), a.rsp1_valid, own);
      chk($sformatf("b2b%0d_rdata", g), own ? a.rsp1_rdata : a.rsp0_rdata, own ? 8'h17 : 8'h10);
      @(negedge clk);
    end
    a.req0_valid = 0;
    a.req1_valid = 1; a.req1_rw = 1; a.req1_addr = 2; a.req1_wdata = 8'h3C;
    #1 chk("mr_rdy1", a.req1_ready, 1);
    @(negedge clk) a.req1_valid = 0;
    #1 chk("mr_sel", a.mem_sel, 8'h04);
    #1 rst = 1'b1;
    a.req0_valid = 1;
    #1 chk("mr_sel_rst", a.mem_sel, 8'h00);
    chk("mr_rw_rst", a.mem_rw, 0);
    chk("mr_rsp1_rst", a.rsp1_valid, 0);
    chk("mr_rdy0_rst", a.req0_ready, 0);
    a.req0_valid = 0;
    @(negedge clk) rst = 1'b0;
    #1 chk("mr_norsp_a", a.rsp1_valid, 0);
    @(negedge clk);
    #1 chk("mr_norsp_b", a.rsp1_valid, 0);
    @(negedge clk) begin a.req1_valid = 1; a.req1_rw = 0; a.req1_addr = 2; end
    #1 chk("mr2_rdy1", a.req1_ready, 1);
    @(negedge clk) a.req1_valid = 0;
    #1 chk("mr2_sel", a.mem_sel, 8'h04);
    chk("mr2_rw", a.mem_rw, 0);
    @(negedge clk);
    #1 chk("mr2_rsp1", a.rsp1_valid, 1);
    chk("mr2_rdata", a.rsp1_rdata, 8'h12);
    @(negedge clk) begin b.req0_valid = 1; b.req0_rw = 0; b.req0_addr = 5; end
    #1 chk("lat_rdy_T", b.req0_ready, 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk) b.req0_valid = 0;
      #1 chk($sformatf("lat_sel%0d", k), b.mem_sel, 8'h20);
      chk($sformatf("lat_rdy%0d", k), b.req0_ready, 0);
      chk($sformatf("lat_rsp%0d", k), b.rsp0_valid, 0);
    end
    @(negedge clk);
    #1 chk("lat_rsp_T4", b.rsp0_valid, 1);
    chk("lat_rdata", b.rsp0_rdata, 8'h5C);
    chk("lat_sel_T4", b.mem_sel, 8'h00);
    chk("lat_rdy_T4", b.req0_ready, 0);
    @(negedge clk);
    #1 chk("lat_rsp_T5", b.rsp0_valid, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 1, meaning: number of cycles mem_sel is held per access (legal range 1-15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an access pending.
REQ-005 req0_rw  input  1  requester 0 access type; 1 = write, 0 = read.
REQ-006 req0_addr  input  3  requester 0 word address (0-7).
REQ-007 req0_wdata  input  8  requester 0 write data.
REQ-008 req0_ready  output  1  requester 0 request accepted this cycle.
REQ-009 rsp0_valid  output  1  requester 0 response strobe.
REQ-010 rsp0_rdata  output  8  requester 0 response data.
REQ-011 req1_valid, req1_rw, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same directions, widths and meanings for requester 1.
REQ-012 mem_sel  output  8  one-hot word select to the 8x8 memory array.
REQ-013 mem_rw  output  1  memory access type; 1 = write, 0 = read.
REQ-014 mem_wdata  output  8  write word to the memory array.
REQ-015 mem_rdata  input  8  read word from the memory array.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-017 In IDLE with at least one reqN_valid, the block SHALL grant one requester, assert that reqN_ready combinationally for that cycle only, latch rw/addr/wdata, and enter ACCESS.
REQ-018 Arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins; a lone requester always wins.
REQ-019 The last-grant pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-020 In ACCESS the block SHALL drive mem_sel = one-hot decode of the latched addr, mem_rw = latched rw, mem_wdata = latched wdata for exactly ACCESS_CYCLES cycles, then enter RESP.
REQ-021 For a read, mem_rdata SHALL be captured on the last ACCESS cycle.
REQ-022 In RESP the block SHALL pulse rspN_valid of the granted requester for one cycle; rspN_rdata = captured word for reads, latched wdata for writes; then return to IDLE.
REQ-023 Latency: grant in cycle T, response in cycle T+ACCESS_CYCLES+1, next grant no earlier than T+ACCESS_CYCLES+2.
REQ-024 Outside ACCESS, mem_sel SHALL be 8'h00 and mem_rw SHALL be 0; mem_sel SHALL never have more than one bit set.
REQ-025 reqN_ready SHALL be 0 in ACCESS and RESP; requesters hold valid and payload stable until ready.
REQ-026 rspN_rdata SHALL hold its value between responses; the non-granted rspN_valid SHALL stay 0.
REQ-027 Requests arriving during ACCESS/RESP SHALL be arbitrated only on return to IDLE.

Reset
REQ-028 On rst assertion, the block SHALL immediately enter IDLE and drive all outputs to 0 regardless of clk.
REQ-029 A transaction in flight at reset SHALL be dropped with no response; mem_sel deasserts immediately.
REQ-030 The last-grant pointer SHALL reset to 1 and internal latches to 0.

Configuration
REQ-031 With macro MEM_ARB_FIXED_PRIORITY_EN defined, requester 0 SHALL win every simultaneous request and the last-grant pointer SHALL be absent.
REQ-032 Without MEM_ARB_FIXED_PRIORITY_EN, arbitration SHALL be round-robin per REQ-018.

Verification
REQ-033 Write then read: req0 write addr 3 data 8'hA5, then req0 read addr 3 -> mem_sel 8'h08, mem_rw 1 then 0; rsp0_rdata 8'hA5.
REQ-034 Tie: both valid from reset, req0 addr 0 and req1 addr 7 -> req0 granted first, req1 next (mem_sel 8'h01 then 8'h80); with MEM_ARB_FIXED_PRIORITY_EN and req0 re-requesting, req1 starved.
REQ-035 Latency: ACCESS_CYCLES=3, single read -> mem_sel high 3 cycles, rsp valid at T+4, ready at T only.
REQ-036 Reset mid-ACCESS: rst asserted during ACCESS -> mem_sel 8'h00 same cycle, no rsp pulse, next request served normally.
REQ-037 Back-to-back: both requesters continuously valid for 8 grants -> strict alternation 0,1,0,1,...; each rsp reaches only its owner.
